stream_upsizer: RTL and testbench
=================================

# stream_upsizer

Valid/ready stream width converter: packs `Ratio` consecutive narrow beats of `DataWidth` bits into one wide beat of `DataWidth*Ratio` bits. A packet-end marker (`last_i`) closes a partial word early, and a per-lane strobe reports which lanes are valid. It sits directly downstream of a spill register on narrow ingress paths, consuming the decoupled narrow stream and feeding wide datapaths at full throughput.

## Interface
Parameters:
- `DataWidth`, default 8: narrow beat width in bits; must be ≥1.
- `Ratio`, default 4: narrow beats per wide beat; must be ≥2. Counter width is `$clog2(Ratio)`.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; one clock; reset is synchronous and active-high.
- `valid_i`  in  1  narrow beat valid.
- `ready_o`  out  1  narrow beat accepted when `valid_i && ready_o`.
- `data_i`  in  `DataWidth`  narrow beat payload.
- `last_i`  in  1  beat is the final beat of a packet; qualified by `valid_i`.
- `valid_o`  out  1  wide beat valid; registered.
- `ready_i`  in  1  downstream accepts when `valid_o && ready_i`.
- `data_o`  out  `DataWidth*Ratio`  wide payload; lane k = bits [k*DataWidth +: DataWidth]; registered.
- `strb_o`  out  `Ratio`  bit k set means lane k holds a valid beat; registered.
- `last_o`  out  1  wide beat closes a packet; registered.

## Operation
- State: lane counter `cnt` (0..Ratio-1), accumulator register (data/strb/last), and `valid_o` flag. Two effective states:
  - FILL (`valid_o=0`).
  - FULL (`valid_o=1`).
- `ready_o = !valid_o || ready_i`. This is combinational from the register and `ready_i`; there is no combinational path from `valid_i`.
- Input handshake in FILL:
  - Write `data_i` into lane `cnt` and set `strb[cnt]`.
  - If `cnt==Ratio-1` or `last_i`: go to FULL, set `last_o<=last_i`, and `cnt<=0`.
  - Otherwise: `cnt<=cnt+1`.
- Output handshake with no input handshake in the same cycle: clear `valid_o`, `data_o`, `strb_o` and `last_o` to 0. `cnt` is already 0.
- Output and input handshake in the same cycle: the accumulator restarts with the new beat.
  - `data_o` = `data_i` in lane 0, all other lanes 0; `strb_o` = 1 in bit 0 only.
  - If `last_i`: stay FULL with `last_o=1` (one-lane word). Otherwise go to FILL with `cnt=1`.
- Lane order: the first beat of a word occupies lane 0 (LSBs). Lanes not written are always 0.
- `strb_o` is always contiguous from bit 0 (pattern 0…01…1).
- Packets never share a wide beat. The beat after `last_i` always starts at lane 0.
- While FILL, `data_o`/`strb_o` show the partial accumulator. They are don't-care to consumers since `valid_o=0`, but the bench checks them as specified.

## Timing
- Reset values: `valid_o=0`, `data_o=0`, `strb_o=0`, `last_o=0`, `cnt=0`. Hence `ready_o=1` after reset.
- Reset mid-fill or mid-FULL discards the partial or pending word with no output. Reset has priority over any handshake in the same cycle.
- Latency: `valid_o` rises the cycle after the handshake of the completing beat (the `Ratio`-th beat or the beat with `last_i`).
- Throughput: one narrow beat per cycle sustained when `ready_i=1`; no bubble between wide beats.
- Backpressure: while `valid_o && !ready_i`, `ready_o=0`, and `data_o`, `strb_o` and `last_o` are held stable.
- `valid_o` never drops without an output handshake, except on reset.
- Upstream must hold `valid_i`/`data_i`/`last_i` stable until accepted. This block does not check that.

## Test plan
- Full word: beats 0x11,0x22,0x33,0x44 on consecutive cycles, `ready_i=1` -> one cycle after the 4th handshake, `valid_o=1`, `data_o=0x44332211`, `strb_o=4'b1111`, `last_o=0` for exactly one cycle.
- Partial packet: 0xAA, then 0xBB with `last_i=1` -> `data_o=0x0000BBAA`, `strb_o=4'b0011`, `last_o=1`. Next beat 0xCC lands in lane 0.
- Last on a boundary: four beats, `last_i` on the 4th -> `strb_o=4'b1111`, `last_o=1`. Single-beat packet 0x5A with `last_i` -> `data_o=0x0000005A`, `strb_o=4'b0001`, `last_o=1`.
- Backpressure: word completes, `ready_i=0` for 5 cycles -> `ready_o=0`, outputs stable throughout. Raise `ready_i` with `valid_i=1` -> output handshake and lane-0 write happen in the same cycle.
- Streaming: 8 beats 0x01..0x08 with `valid_i` and `ready_i` constant 1 -> `ready_o` never low; wide beats `0x04030201` then `0x08070605` on consecutive 4-cycle boundaries.
- Reset mid-fill: 2 beats accepted, assert `rst_i` one cycle -> all outputs 0, `ready_o=1`. Next 4 beats 0xA1..0xA4 -> `data_o=0xA4A3A2A1`, `strb_o=4'b1111`.

Source files
------------

// File: rtl/stream_upsizer.sv
// -----------------------------------------------------------------------------
// stream_upsizer
//
// Valid/ready stream width converter. Packs Ratio consecutive narrow beats of
// DataWidth bits into one wide beat of DataWidth*Ratio bits. A beat carrying
// last_i closes the current wide word early, so packets never share a wide
// beat. strb_o marks which lanes of the wide word hold valid beats; it is
// always contiguous from lane 0 and unwritten lanes read as zero.
//
// Ports:
//   clk_i    in   1                  clock, rising edge
//   rst_i    in   1                  synchronous active-high reset
//   valid_i  in   1                  narrow beat valid
//   ready_o  out  1                  narrow beat accepted on valid_i && ready_o
//   data_i   in   DataWidth          narrow beat payload
//   last_i   in   1                  narrow beat ends a packet
//   valid_o  out  1                  wide beat valid (registered)
//   ready_i  in   1                  downstream accepts on valid_o && ready_i
//   data_o   out  DataWidth*Ratio    wide payload, lane k at [k*DataWidth +: DataWidth]
//   strb_o   out  Ratio              per-lane valid strobe (registered)
//   last_o   out  1                  wide beat ends a packet (registered)
// -----------------------------------------------------------------------------
module stream_upsizer #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned Ratio     = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [DataWidth-1:0]         data_i,
    input  logic                         last_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [DataWidth*Ratio-1:0]   data_o,
    output logic [Ratio-1:0]             strb_o,
    output logic                         last_o
);

    localparam int unsigned CntWidth  = $clog2(Ratio);
    localparam int unsigned WideWidth = DataWidth * Ratio;
    localparam logic [CntWidth-1:0] LastLane = CntWidth'(Ratio - 1);

    // FILL: accumulating a word, nothing offered downstream.
    // FULL: a complete word is presented on the outputs.
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q,   cnt_d;
    logic [WideWidth-1:0]  data_q,  data_d;
    logic [Ratio-1:0]      strb_q,  strb_d;
    logic                  last_q,  last_d;

    logic in_hs;
    logic out_hs;

    assign valid_o = (state_q == FULL);
    // Depends only on the state register and ready_i, never on valid_i, so
    // the upstream spill register sees no combinational loop through us.
    assign ready_o = !valid_o || ready_i;
    assign in_hs   = valid_i && ready_o;
    assign out_hs  = valid_o && ready_i;

    assign data_o  = data_q;
    assign strb_o  = strb_q;
    assign last_o  = last_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        strb_d  = strb_q;
        last_d  = last_q;

        if (out_hs && in_hs) begin
            // The word leaves while the next beat arrives: restart the
            // accumulator with the new beat in lane 0.
            data_d                 = '0;
            data_d[DataWidth-1:0]  = data_i;
            strb_d                 = '0;
            strb_d[0]              = 1'b1;
            if (last_i) begin
                state_d = FULL;
                last_d  = 1'b1;
                cnt_d   = '0;
            end else begin
                state_d = FILL;
                last_d  = 1'b0;
                cnt_d   = CntWidth'(1);
            end
        end else if (out_hs) begin
            state_d = FILL;
            cnt_d   = '0;
            data_d  = '0;
            strb_d  = '0;
            last_d  = 1'b0;
        end else if (in_hs) begin
            // Only reachable in FILL: in FULL, ready_o implies ready_i.
            for (int k = 0; k < Ratio; k++) begin
                if (cnt_q == CntWidth'(k)) begin
                    data_d[k*DataWidth +: DataWidth] = data_i;
                    strb_d[k]                        = 1'b1;
                end
            end
            if (cnt_q == LastLane || last_i) begin
                state_d = FULL;
                last_d  = last_i;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_stream_upsizer.sv
// -----------------------------------------------------------------------------
// tb_stream_upsizer
//
// Bench for stream_upsizer (DataWidth=8, Ratio=4). A per-cycle vector table
// carries inputs and the outputs expected just before that cycle's clock edge.
// A packing model pushes each completed wide word into a scoreboard queue as
// beats are driven; words are compared while presented and popped on the
// output handshake. Hand-written streaming and randomized sequences follow.
// -----------------------------------------------------------------------------
module tb_stream_upsizer;

    logic        clk_i;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [7:0]  data_i;
    logic        last_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic [3:0]  strb_o;
    logic        last_o;

    stream_upsizer #(
        .DataWidth (8),
        .Ratio     (4)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .last_i  (last_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .strb_o  (strb_o),
        .last_o  (last_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic        vin;
        logic [7:0]  din;
        logic        lin;
        logic        rin;
        logic        e_ready;
        logic        e_valid;
        logic [31:0] e_data;
        logic [3:0]  e_strb;
        logic        e_last;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
    } word_t;

    int    n_pass  = 0;
    int    n_total = 0;

    word_t       sbq[$];
    logic [31:0] m_data;
    logic [3:0]  m_strb;
    int          m_cnt;
    logic        m_in_hs;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic vin, input logic [7:0] din,
                                input logic lin, input logic rin, input logic er,
                                input logic ev, input logic [31:0] ed,
                                input logic [3:0] es, input logic el);
        vec_t v;
        v.rst = rst; v.vin = vin; v.din = din; v.lin = lin; v.rin = rin;
        v.e_ready = er; v.e_valid = ev; v.e_data = ed; v.e_strb = es; v.e_last = el;
        return v;
    endfunction

    // Drive one cycle's inputs after the falling edge, let them settle, then
    // compare against the scoreboard and advance the packing model.
    task automatic step(input logic rst, input logic vin, input logic [7:0] din,
                        input logic lin, input logic rin);
        logic m_valid;
        logic m_ready;
        @(negedge clk_i);
        rst_i   = rst;
        valid_i = vin;
        data_i  = din;
        last_i  = lin;
        ready_i = rin;
        #1;
        m_valid = (sbq.size() != 0);
        m_ready = !m_valid || rin;
        check("sb_valid", valid_o, m_valid);
        check("sb_ready", ready_o, m_ready);
        if (m_valid) begin
            check("sb_data", data_o, sbq[0].d);
            check("sb_strb", strb_o, sbq[0].s);
            check("sb_last", last_o, sbq[0].l);
        end
        m_in_hs = 1'b0;
        if (rst) begin
            sbq.delete();
            m_data = '0;
            m_strb = '0;
            m_cnt  = 0;
        end else begin
            if (m_valid && rin) void'(sbq.pop_front());
            if (vin && m_ready) begin
                m_in_hs = 1'b1;
                m_data[m_cnt*8 +: 8] = din;
                m_strb[m_cnt]        = 1'b1;
                if (m_cnt == 3 || lin) begin
                    sbq.push_back('{d: m_data, s: m_strb, l: lin});
                    m_data = '0;
                    m_strb = '0;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    initial begin
        logic       rv;
        logic [7:0] rd;
        logic       rl;

        rst_i = 1'b1; valid_i = 1'b0; data_i = '0; last_i = 1'b0; ready_i = 1'b0;
        m_data = '0; m_strb = '0; m_cnt = 0; m_in_hs = 1'b0;

        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);

        //            rst v  din    l  r   rdy vld data           strb     last
        // reset state
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,  1, 0, 32'h00000000, 4'b0000, 0));
        // full word
        vecs.push_back(mk(0, 1, 8'h11, 0, 1,  1, 0, 32'h00000000, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 8'h22, 0, 1,  1, 0, 32'h00000011, 4'b0001, 0));
        vecs.push_back(mk(0, 1, 8'h33, 0, 1,  1, 0, 32'h00002211, 4'b0011, 0));
        vecs.push_back(mk(0, 1, 8'h44, 0, 1,  1, 0, 32'h00332211, 4'b0111, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,  1, 1, 32'h44332211, 4'b1111, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,  1, 0, 32'h00000000, 4'b0000, 0));
        // partial packet, then next beat lands in lane 0
        vecs.push_back(mk(0, 1, 8'hAA, 0, 1,  1, 0, 32'h00000000, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 8'hBB, 1, 1,  1, 0, 32'h000000AA, 4'b0001, 0));
        vecs.push_back(mk(0, 1, 8'hCC, 0, 1,  1, 1, 32'h0000BBAA, 4'b0011, 1));
        vecs.push_back(mk(0, 1, 8'hDD, 1, 1,  1, 0, 32'h000000CC, 4'b0001, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,  1, 1, 32'h0000DDCC, 4'b0011, 1));
        // last on the boundary, then single-beat packet in a simultaneous handshake
        vecs.push_back(mk(0, 1, 8'h01, 0, 1,  1, 0, 32'h00000000, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 8'h02, 0, 1,  1, 0, 32'h00000001, 4'b0001, 0));
        vecs.push_back(mk(0, 1, 8'h03, 0, 1,  1, 0, 32'h00000201, 4'b0011, 0));
        vecs.push_back(mk(0, 1, 8'h04, 1, 1,  1, 0, 32'h00030201, 4'b0111, 0));
        vecs.push_back(mk(0, 1, 8'h5A, 1, 1,  1, 1, 32'h04030201, 4'b1111, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,  1, 1, 32'h0000005A, 4'b0001, 1));
        // backpressure: five stalled cycles, then release with a beat waiting
        vecs.push_back(mk(0, 1, 8'h10, 0, 1,  1, 0, 32'h00000000, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 8'h20, 0, 1,  1, 0, 32'h00000010, 4'b0001, 0));
        vecs.push_back(mk(0, 1, 8'h30, 0, 1,  1, 0, 32'h00002010, 4'b0011, 0));
        vecs.push_back(mk(0, 1, 8'h40, 0, 0,  1, 0, 32'h00302010, 4'b0111, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 8'h50, 0, 0,  0, 1, 32'h40302010, 4'b1111, 0));
        vecs.push_back(mk(0, 1, 8'h50, 0, 1,  1, 1, 32'h40302010, 4'b1111, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,  1, 0, 32'h00000050, 4'b0001, 0));
        // reset mid-fill with a beat offered in the reset cycle
        vecs.push_back(mk(0, 1, 8'h60, 0, 1,  1, 0, 32'h00000050, 4'b0001, 0));
        vecs.push_back(mk(1, 1, 8'h70, 0, 1,  1, 0, 32'h00006050, 4'b0011, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,  1, 0, 32'h00000000, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 8'hA1, 0, 1,  1, 0, 32'h00000000, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 8'hA2, 0, 1,  1, 0, 32'h000000A1, 4'b0001, 0));
        vecs.push_back(mk(0, 1, 8'hA3, 0, 1,  1, 0, 32'h0000A2A1, 4'b0011, 0));
        vecs.push_back(mk(0, 1, 8'hA4, 0, 1,  1, 0, 32'h00A3A2A1, 4'b0111, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,  1, 1, 32'hA4A3A2A1, 4'b1111, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,  1, 0, 32'h00000000, 4'b0000, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].vin, vecs[i].din, vecs[i].lin, vecs[i].rin);
            check($sformatf("v%0d_ready", i), ready_o, vecs[i].e_ready);
            check($sformatf("v%0d_valid", i), valid_o, vecs[i].e_valid);
            check($sformatf("v%0d_data",  i), data_o,  vecs[i].e_data);
            check($sformatf("v%0d_strb",  i), strb_o,  vecs[i].e_strb);
            check($sformatf("v%0d_last",  i), last_o,  vecs[i].e_last);
        end

        // Streaming: 8 beats back to back, wide beats on consecutive 4-cycle
        // boundaries with no bubble; the scoreboard checks their contents.
        for (int i = 0; i < 10; i++) begin
            step(0, (i < 8), 8'(i + 1), 0, 1);
            check($sformatf("stream%0d_ready", i), ready_o, 1'b1);
            check($sformatf("stream%0d_valid", i), valid_o, (i == 4 || i == 8));
            if (i == 4) check("stream_word0", data_o, 32'h04030201);
            if (i == 8) check("stream_word1", data_o, 32'h08070605);
        end

        // Randomized traffic; upstream holds its beat until accepted.
        rv = 1'b0; rd = '0; rl = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!rv || m_in_hs) begin
                rv = ($urandom_range(0, 3) != 0);
                rd = 8'($urandom_range(0, 255));
                rl = ($urandom_range(0, 4) == 0);
            end
            step(0, rv, rd, rl, ($urandom_range(0, 3) != 0));
        end
        // Finish any open packet and drain.
        if (rv && !m_in_hs) begin
            for (int i = 0; i < 8 && !m_in_hs; i++) step(0, 1, rd, 1, 1);
        end
        step(0, 1, 8'hEE, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 1);
        check("sb_drained", 64'(sbq.size()), 64'd0);
        check("final_valid", valid_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
